// File: rtl/ram_controller.sv
// Byte-wide RAM behind a word request/ack handshake; one byte moves per cycle.
// Define RAM_BOUNDS_CHECK_EN to fault word accesses that would run past the top of the RAM.
module ram_controller #(
    parameter int unsigned RAMSIZE = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        readReq,
    input  logic        writeReq,
    input  logic [7:0]  ramAddress,
    input  logic [31:0] ramOut,
    output logic [31:0] ramValue,
    output logic        readAck,
    output logic        writeAck,
    output logic        addrError
);

    localparam int unsigned AW = $clog2(RAMSIZE);

    typedef enum logic [2:0] {StIdle, StRd, StWr, StRack, StWack} stateT;

    stateT         stateQ, stateD;
    logic [AW-1:0] addrQ;
    logic [31:0]   dataQ;
    logic [1:0]    cntQ;
    logic          errQ;
    logic          outOfRange;
    logic [AW-1:0] byteIdx;
    logic [7:0]    mem [RAMSIZE];

`ifdef RAM_BOUNDS_CHECK_EN
    assign outOfRange = 32'(ramAddress) > (RAMSIZE - 32'd4);
`else
    assign outOfRange = 1'b0;
`endif

    // Truncation to AW bits gives the modulo-RAMSIZE wrap for free.
    assign byteIdx = addrQ + AW'(cntQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle: begin
                if (readReq) begin
                    stateD = StRd;
                end else if (writeReq) begin
                    stateD = StWr;
                end
            end
            // A faulted access spends a single cycle here so its ack lands one edge after sampling.
            StRd:    if (errQ || cntQ == 2'd3) stateD = StRack;
            StWr:    if (errQ || cntQ == 2'd3) stateD = StWack;
            StRack:  if (!readReq) stateD = StIdle;
            StWack:  if (!writeReq) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        readAck  = (stateQ == StRack);
        writeAck = (stateQ == StWack);
`ifdef RAM_BOUNDS_CHECK_EN
        addrError = errQ && (stateQ == StRack || stateQ == StWack);
`else
        addrError = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addrQ    <= '0;
            dataQ    <= '0;
            cntQ     <= '0;
            errQ     <= 1'b0;
            ramValue <= '0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (readReq || writeReq) begin
                        addrQ <= ramAddress[AW-1:0];
                        cntQ  <= '0;
                        errQ  <= outOfRange;
                        if (!readReq) begin
                            dataQ <= ramOut;
                        end
                    end
                end
                StRd: begin
                    if (errQ) begin
                        ramValue <= '0;
                    end else begin
                        ramValue[{cntQ, 3'b000} +: 8] <= mem[byteIdx];
                    end
                    cntQ <= cntQ + 2'd1;
                end
                StWr:    cntQ <= cntQ + 2'd1;
                default: ;
            endcase
        end
    end

    // Storage has no reset so contents survive a reset mid-transfer.
    always_ff @(posedge clk) begin
        if (stateQ == StWr && !errQ) begin
            mem[byteIdx] <= dataQ[{cntQ, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_ram_controller.sv
// Self-checking bench for ram_controller: directed vector table, handshake corner
// sequences and random traffic checked against a byte-array reference model.
module tb_ram_controller;

    localparam int RS = 256;
`ifdef RAM_BOUNDS_CHECK_EN
    localparam bit BoundsChk = 1'b1;
`else
    localparam bit BoundsChk = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        readReq;
    logic        writeReq;
    logic [7:0]  ramAddress;
    logic [31:0] ramOut;
    logic [31:0] ramValue;
    logic        readAck;
    logic        writeAck;
    logic        addrError;

    ram_controller #(.RAMSIZE(RS)) dut (
        .clk       (clk),
        .reset     (reset),
        .readReq   (readReq),
        .writeReq  (writeReq),
        .ramAddress(ramAddress),
        .ramOut    (ramOut),
        .ramValue  (ramValue),
        .readAck   (readAck),
        .writeAck  (writeAck),
        .addrError (addrError)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        bit          isRead;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] expValue;
        int          expLat;
        bit          expErr;
    } vecT;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model [RS];
    logic [31:0] lastRead = '0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] modelRead(logic [7:0] a);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = model[(int'(a) + k) % RS];
        return r;
    endfunction

    // Expected result of one transaction; also commits its effect to the model.
    task automatic modelApply(input bit isRead, input logic [7:0] addr, input logic [31:0] data,
                              output logic [31:0] expV, output int expLat, output bit expErr);
        bit bad;
        bad    = BoundsChk && (int'(addr) > RS - 4);
        expLat = bad ? 1 : 4;
        expErr = bad;
        if (isRead) begin
            expV     = bad ? 32'h0 : modelRead(addr);
            lastRead = expV;
        end else begin
            if (!bad) begin
                for (int k = 0; k < 4; k++) model[(int'(addr) + k) % RS] = data[8*k +: 8];
            end
            expV = lastRead;
        end
    endtask

    task automatic txn(input bit isRead, input logic [7:0] addr, input logic [31:0] data,
                       output logic [31:0] got, output int lat, output bit err,
                       output bit cleared);
        @(negedge clk);
        readReq    = isRead;
        writeReq   = !isRead;
        ramAddress = addr;
        ramOut     = data;
        @(posedge clk);
        #1;
        // Inputs must be ignored once sampled.
        ramAddress = 8'($urandom);
        ramOut     = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!(isRead ? readAck : writeAck) && lat < 12);
        got = ramValue;
        err = addrError;
        @(negedge clk);
        readReq  = 1'b0;
        writeReq = 1'b0;
        @(posedge clk);
        #1;
        cleared = !readAck && !writeAck && !addrError;
    endtask

    task automatic runChecked(input string name, input bit isRead, input logic [7:0] addr,
                              input logic [31:0] data);
        logic [31:0] got, expV;
        int          lat, expLat;
        bit          err, expErr, clr;
        txn(isRead, addr, data, got, lat, err, clr);
        modelApply(isRead, addr, data, expV, expLat, expErr);
        check({name, " value"}, got, expV);
        check({name, " latency"}, 32'(lat), 32'(expLat));
        check({name, " addrError"}, 32'(err), 32'(expErr));
        check({name, " ack clear"}, 32'(clr), 32'd1);
    endtask

    vecT         vecs [10];
    logic [31:0] got, expV;
    int          lat, expLat, cnt;
    bit          err, expErr, clr;

    initial begin
        vecs[0] = '{0, 8'h00, 32'h00000000, 32'h00000000, 4, 0};
        vecs[1] = '{0, 8'h04, 32'h00000000, 32'h00000000, 4, 0};
        vecs[2] = '{0, 8'h10, 32'hDEADBEEF, 32'h00000000, 4, 0};
        vecs[3] = '{1, 8'h10, 32'h0,        32'hDEADBEEF, 4, 0};
        vecs[4] = '{0, 8'hFC, 32'h01020304, 32'hDEADBEEF, 4, 0};
        vecs[5] = '{0, 8'hFE, 32'hAABBCCDD, 32'hDEADBEEF, BoundsChk ? 1 : 4, BoundsChk};
        vecs[6] = '{1, 8'h00, 32'h0, BoundsChk ? 32'h0 : 32'h0000AABB, 4, 0};
        vecs[7] = '{1, 8'hFC, 32'h0, BoundsChk ? 32'h01020304 : 32'hCCDD0304, 4, 0};
        vecs[8] = '{1, 8'hFD, 32'h0, BoundsChk ? 32'h0 : 32'hBBCCDD03,
                    BoundsChk ? 1 : 4, BoundsChk};
        vecs[9] = '{1, 8'h10, 32'h0,        32'hDEADBEEF, 4, 0};

        reset = 1'b0; readReq = 1'b0; writeReq = 1'b0; ramAddress = '0; ramOut = '0;
        repeat (2) @(negedge clk);
        check("reset ramValue", ramValue, 32'h0);
        check("reset readAck", 32'(readAck), 32'd0);
        check("reset writeAck", 32'(writeAck), 32'd0);
        check("reset addrError", 32'(addrError), 32'd0);
        reset = 1'b1;

        // Fill the whole RAM with known contents.
        for (int a = 0; a < RS; a += 4) begin
            logic [31:0] d;
            d = $urandom;
            txn(1'b0, 8'(a), d, got, lat, err, clr);
            modelApply(1'b0, 8'(a), d, expV, expLat, expErr);
        end

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].isRead, vecs[i].addr, vecs[i].data, got, lat, err, clr);
            modelApply(vecs[i].isRead, vecs[i].addr, vecs[i].data, expV, expLat, expErr);
            check($sformatf("vec%0d value", i), got, vecs[i].expValue);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].expLat));
            check($sformatf("vec%0d addrError", i), 32'(err), 32'(vecs[i].expErr));
            check($sformatf("vec%0d ack clear", i), 32'(clr), 32'd1);
        end

        // Request held through the ack state: ack stays up, no second transfer.
        @(negedge clk);
        readReq = 1'b1; ramAddress = 8'h10;
        @(posedge clk);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!readAck && lat < 12);
        modelApply(1'b1, 8'h10, 32'h0, expV, expLat, expErr);
        check("held latency", 32'(lat), 32'd4);
        check("held value", ramValue, expV);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (readAck) cnt++; end
        check("held ack cycles", 32'(cnt), 32'd4);
        @(negedge clk);
        readReq = 1'b0;
        @(posedge clk); #1;
        check("held ack clear", 32'(readAck), 32'd0);
        cnt = 0;
        repeat (6) begin @(posedge clk); #1; if (readAck || writeAck) cnt++; end
        check("held no retrigger", 32'(cnt), 32'd0);

        // Request dropped mid-read still completes and acks at N+4.
        @(negedge clk);
        readReq = 1'b1; ramAddress = 8'h04;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        readReq = 1'b0;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        modelApply(1'b1, 8'h04, 32'h0, expV, expLat, expErr);
        check("drop ack", 32'(readAck), 32'd1);
        check("drop value", ramValue, expV);
        @(posedge clk); #1;
        check("drop ack clear", 32'(readAck), 32'd0);

        // Simultaneous read and write: read first with old data, then the write.
        runChecked("pre20 write", 1'b0, 8'h20, 32'hCAFEF00D);
        @(negedge clk);
        readReq = 1'b1; writeReq = 1'b1; ramAddress = 8'h20; ramOut = 32'h12345678;
        @(posedge clk);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!readAck && lat < 12);
        modelApply(1'b1, 8'h20, 32'h0, expV, expLat, expErr);
        check("both read latency", 32'(lat), 32'd4);
        check("both read value", ramValue, expV);
        check("both no writeAck", 32'(writeAck), 32'd0);
        @(negedge clk);
        readReq = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!writeAck && lat < 12);
        modelApply(1'b0, 8'h20, 32'h12345678, expV, expLat, expErr);
        check("both write latency", 32'(lat), 32'd6);
        check("both write ramValue", ramValue, expV);
        @(negedge clk);
        writeReq = 1'b0;
        @(posedge clk); #1;
        check("both writeAck clear", 32'(writeAck), 32'd0);
        runChecked("post20 read", 1'b1, 8'h20, 32'h0);

        // Reset during a write: outputs clear at once, only byte 0 lands.
        runChecked("prerst read", 1'b1, 8'h10, 32'h0);
        @(negedge clk);
        writeReq = 1'b1; ramAddress = 8'h40; ramOut = 32'h11223344;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst ramValue", ramValue, 32'h0);
        check("rst readAck", 32'(readAck), 32'd0);
        check("rst writeAck", 32'(writeAck), 32'd0);
        check("rst addrError", 32'(addrError), 32'd0);
        writeReq = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model[8'h40] = 8'h44;
        txn(1'b1, 8'h40, 32'h0, got, lat, err, clr);
        check("rst read latency", 32'(lat), 32'd4);
        check("rst byte40", 32'(got[7:0]), 32'h44);
        check("rst byte43", 32'(got[31:24]), 32'(model[8'h43]));
        txn(1'b0, 8'h40, 32'h55AA33CC, got, lat, err, clr);
        modelApply(1'b0, 8'h40, 32'h55AA33CC, expV, expLat, expErr);
        runChecked("rst reread", 1'b1, 8'h40, 32'h0);

        for (int i = 0; i < 60; i++) begin
            runChecked($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 8'($urandom),
                       $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
